// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitIdle
    } rx_state_e;

    localparam int unsigned Ovs           = 16;
    localparam int unsigned ScntW         = $clog2(Ovs);
    localparam logic [ScntW-1:0] MidSample  = ScntW'(7);
    localparam logic [ScntW-1:0] LastSample = ScntW'(15);
    localparam int unsigned DefaultClkDiv = 326;
    localparam int unsigned DivW          = 12;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; a full FIFO still accepts a write
// when a read happens in the same cycle.
module sync_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    rd_en,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    empty,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]   wptr_q, rptr_q;
    logic [PtrW:0]     count_q, count_d;
    logic              do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PtrW+1)'(DEPTH));
    assign count   = count_q;
    assign do_pop  = rd_en & ~empty;
    assign do_push = wr_en & (~full | do_pop);
    // Gate the head so the output reads zero whenever nothing is stored.
    assign rd_data = empty ? '0 : mem_q[rptr_q];

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PtrW+1)'(1);
            2'b01:   count_d = count_q - (PtrW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PtrW'(1);
            if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wr_data;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 16x-oversampled 8N1 UART receiver feeding a byte FIFO, all in the clk domain.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV = DefaultClkDiv,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned DATA_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rxd,
    input  logic                    rd_en,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    empty,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    frame_err,
    output logic                    overrun
);

    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
    localparam logic [2:0]      BitLast = 3'(DATA_W - 1);

    logic              rx_meta_q, rxs_q;
    logic [DivW-1:0]   div_q;
    logic              tick;
    rx_state_e         state_q, state_d;
    logic [ScntW-1:0]  scnt_q, scnt_d;
    logic [2:0]        bcnt_q, bcnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              push_q, push_d;
    logic              ferr_q, ferr_d;

    // Free-running divider; deliberately not realigned to the start edge.
    assign tick = (div_q == DivLast);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
            div_q     <= '0;
            state_q   <= StIdle;
            scnt_q    <= '0;
            bcnt_q    <= '0;
            shift_q   <= '0;
            push_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= rxd;
            rxs_q     <= rx_meta_q;
            div_q     <= tick ? '0 : div_q + DivW'(1);
            state_q   <= state_d;
            scnt_q    <= scnt_d;
            bcnt_q    <= bcnt_d;
            shift_q   <= shift_d;
            push_q    <= push_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        bcnt_d  = bcnt_q;
        shift_d = shift_q;
        push_d  = 1'b0;
        ferr_d  = 1'b0;
        if (tick) begin
            case (state_q)
                StIdle: begin
                    if (!rxs_q) begin
                        state_d = StStart;
                        scnt_d  = '0;
                    end
                end
                StStart: begin
                    if (scnt_q == MidSample) begin
                        scnt_d  = '0;
                        bcnt_d  = '0;
                        state_d = rxs_q ? StIdle : StData;
                    end else begin
                        scnt_d = scnt_q + ScntW'(1);
                    end
                end
                StData: begin
                    scnt_d = scnt_q + ScntW'(1);
                    if (scnt_q == LastSample) begin
                        shift_d = {rxs_q, shift_q[DATA_W-1:1]};
                        bcnt_d  = bcnt_q + 3'd1;
                        if (bcnt_q == BitLast) begin
                            state_d = StStop;
                            scnt_d  = '0;
                        end
                    end
                end
                StStop: begin
                    scnt_d = scnt_q + ScntW'(1);
                    if (scnt_q == LastSample) begin
                        if (rxs_q) begin
                            push_d  = 1'b1;
                            state_d = StIdle;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = StWaitIdle;
                        end
                    end
                end
                StWaitIdle: begin
                    // Hold off a held-low break from looking like a new start bit.
                    if (rxs_q) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign frame_err = ferr_q;
    assign overrun   = push_q & full & ~rd_en;

    sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_q),
        .wr_data (shift_q),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .empty   (empty),
        .full    (full),
        .count   (count)
    );

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- 16x-oversampling UART receive front-end with its own sample-tick divider.
- Recovers 8N1 frames from the serial line and pushes each good byte into an internal FIFO; the downstream consumer pops bytes with a read strobe.
- Sits between the serial pin and the memory-receive stage, and replaces bit sampling on a divided clock with clean single-clock-domain sampling.

Parameters:
- CLK_DIV, 326, system clocks per 16x sample tick (50 MHz / (9600*16)); legal range 2..4095.
- DEPTH, 16, FIFO depth in bytes; must be a power of 2, minimum 2.
- DATA_W, 8, data bits per frame (fixed at 8 for 8N1).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- rxd  in  1  asynchronous serial input; idle high.
- rd_en  in  1  pop strobe; ignored when empty=1.
- rd_data  out  8  FIFO head byte (first-word fall-through); valid while empty=0.
- empty  out  1  FIFO holds 0 bytes.
- full  out  1  FIFO holds DEPTH bytes.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- frame_err  out  1  one-clk pulse: stop bit sampled low.
- overrun  out  1  one-clk pulse: good byte dropped because FIFO full.

Behaviour:
- Reset values: empty=1, full=0, count=0, frame_err=0, overrun=0, rd_data=0.
- Reset also sets FSM=IDLE, both synchronizer flops=1, tick counter=0, and both FIFO pointers=0.
- A reset mid-frame discards the partial byte.
- Synchronizer: 2 flops on rxd; the FSM sees only rxs (2nd flop).
- Tick divider: counts 0..CLK_DIV-1. tick=1 for one clk when the count equals CLK_DIV-1, then the counter wraps to 0. It free-runs; it is not resynchronized on the start edge.
- FSM states (all advance only on tick; scnt is a 4-bit tick count, bcnt a 3-bit bit index):
  - IDLE: if rxs=0 -> START, scnt=0.
  - START: scnt increments. At scnt=7: rxs=0 -> DATA with scnt=0, bcnt=0; rxs=1 -> IDLE (glitch rejected, no flag).
  - DATA: at scnt=15, shift rxs into bit bcnt (LSB first). After bcnt=7 -> STOP with scnt=0.
  - STOP: at scnt=15, sample rxs. rxs=1 -> push byte, go IDLE. rxs=0 -> pulse frame_err, drop byte, go WAIT_IDLE.
  - WAIT_IDLE: stay until rxs=1 on a tick -> IDLE. This prevents a break condition from re-triggering a start.
- Push timing: push asserts for one clk, on the clk after the stop-bit sampling tick. empty deasserts, and rd_data becomes valid, on the following clk.
- FIFO rules:
  - Pointers are log2(DEPTH) bits and wrap naturally. count is updated in the same cycle as each push and pop.
  - Push is accepted if full=0, or if full=1 and rd_en=1 in the same cycle. Otherwise the byte is dropped and overrun pulses in the push cycle.
  - A pop while empty=1 is ignored: no pointer change, count stays 0.
  - Simultaneous push and pop on a non-empty FIFO: count is unchanged, both pointers advance.
  - Simultaneous push and pop on an empty FIFO: the pop is ignored and the push is accepted.
- frame_err and overrun are never asserted in the same cycle as each other.

Decomposition:
- Package uart_pkg: state enum (IDLE, START, DATA, STOP, WAIT_IDLE), OVS=16, MID_SAMPLE=7, LAST_SAMPLE=15, and the default CLK_DIV value.
- Sub-module sync_fifo (params DEPTH, DATA_W; ports clk, rst, wr_en, wr_data, rd_en, rd_data, empty, full, count). It will also be reused on the transmit side.
- The top level contains the synchronizer, tick divider and FSM.

Test Plan:
- Single frame: CLK_DIV=4, send 0xA5 at 64 clk/bit -> empty falls 2 clks after the stop-sample tick; rd_data=0xA5, count=1; rd_en for one clk -> empty=1, count=0.
- Glitch: rxd low for 20 clks (under half a bit, 32 clks) -> FSM returns to IDLE; no push, frame_err=0, empty stays 1.
- Framing error: send 0x3C with stop bit 0, then hold rxd low 200 clks, then high -> exactly one frame_err pulse, count=0, no new start detected until rxd returns high.
- Full/overrun: DEPTH=4, send 0x01..0x05 with no reads -> full=1 after 4th, overrun pulses once on 5th; pops yield 0x01,0x02,0x03,0x04.
- Simultaneous: with FIFO full (4 bytes), assert rd_en exactly on the push cycle of 0x55 -> no overrun, count stays 4, final pop returns 0x55.
- Reset mid-frame: assert rst during DATA bit 3 of 0xFF, then send 0x12 -> only 0x12 appears in FIFO; all outputs show reset values the clk after rst.
